// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, widths and sequencer state encoding.
package alu_pkg;

    localparam int ALU_OPW     = 2;
    localparam int ALU_DW      = 3;
    localparam int ALU_QW      = 4;
    localparam int NUM_VECTORS = 256;
    localparam int IDX_W       = ALU_OPW + 2 * ALU_DW;
    localparam int CNT_W       = IDX_W + 1;

    localparam logic [IDX_W-1:0] NO_FAIL_IDX = 8'hFF;
    localparam logic [IDX_W-1:0] LAST_IDX    = 8'(NUM_VECTORS - 1);

    typedef enum logic [ALU_OPW-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_BEQ  = 2'b10,
        OP_HALF = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference for the 3-bit ALU: (op, a, b) -> expected 4-bit q.
module alu_golden_model
    import alu_pkg::*;
(
    input  logic [ALU_OPW-1:0] op_i,
    input  logic [ALU_DW-1:0]  a_i,
    input  logic [ALU_DW-1:0]  b_i,
    output logic [ALU_QW-1:0]  q_o
);

    always_comb begin
        q_o = '0;
        case (op_i)
            OP_ADD:  q_o = {1'b0, a_i} + {1'b0, b_i};
            // Borrow flag in the top bit, modulo-8 difference below.
            OP_SUB:  q_o = {(a_i < b_i), 3'(a_i - b_i)};
            OP_BEQ:  q_o = {1'b0, ~(a_i ^ b_i)};
            OP_HALF: q_o = {1'b0, a_i >> 1};
            default: q_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_vector_sequencer.sv
// Sweeps all 256 {op,a,b} vectors into the ALU and scores q against the golden model.
// Build option ALU_SEQ_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module alu_vector_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int OPW           = 2,
    parameter int DW            = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [OPW-1:0] swSelect,
    output logic [DW-1:0]  a,
    output logic [DW-1:0]  b,
    input  logic [DW:0]    q,
    output logic           busy,
    output logic           done,
    output logic [8:0]     pass_cnt,
    output logic [8:0]     fail_cnt,
    output logic [7:0]     first_fail_idx,
    output logic           any_fail
);

`ifdef ALU_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [3:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    seq_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  drive_q;
    logic [3:0]        settle_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  pass_q;
    logic [CNT_W-1:0]  fail_q;
    logic [IDX_W-1:0]  first_fail_q;
    logic              any_fail_q;

    logic [ALU_QW-1:0] golden_q_w;
    logic              match_w;
    logic              last_w;
    logic [IDX_W-1:0]  idx_d;

    // The golden model sees the registered drive value, identical to what the ALU sees.
    alu_golden_model u_golden (
        .op_i (drive_q[IDX_W-1 -: ALU_OPW]),
        .a_i  (drive_q[2*ALU_DW-1 -: ALU_DW]),
        .b_i  (drive_q[ALU_DW-1:0]),
        .q_o  (golden_q_w)
    );

    assign match_w = (q == golden_q_w);
    assign last_w  = (idx_q == LAST_IDX) || (STOP_ON_FAIL && !match_w);
    assign idx_d   = idx_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            drive_q      <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= '0;
            fail_q       <= '0;
            first_fail_q <= NO_FAIL_IDX;
            any_fail_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // done is registered off the DONE state, so it rises one edge after entry.
                    done_q <= (state_q == DONE) && !start;
                    if (start) begin
                        state_q      <= DRIVE;
                        idx_q        <= '0;
                        busy_q       <= 1'b1;
                        pass_q       <= '0;
                        fail_q       <= '0;
                        first_fail_q <= NO_FAIL_IDX;
                        any_fail_q   <= 1'b0;
                    end
                end
                DRIVE: begin
                    drive_q  <= idx_q;
                    settle_q <= SETTLE_LOAD;
                    state_q  <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                CHECK: begin
                    if (match_w) begin
                        pass_q <= pass_q + 9'd1;
                    end else begin
                        fail_q <= fail_q + 9'd1;
                        if (!any_fail_q) begin
                            first_fail_q <= idx_q;
                            any_fail_q   <= 1'b1;
                        end
                    end
                    if (last_w) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_d;
                        state_q <= DRIVE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign swSelect       = drive_q[IDX_W-1 -: ALU_OPW];
    assign a              = drive_q[2*ALU_DW-1 -: ALU_DW];
    assign b              = drive_q[ALU_DW-1:0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign first_fail_idx = first_fail_q;
    assign any_fail       = any_fail_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: ALU stubs with injectable faults and a timing-based sweep model.
module tb_alu_vector_sequencer;

    localparam int S  = 2;
    localparam int P  = S + 2;
    localparam int P0 = 2;
`ifdef ALU_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    logic [1:0] sw, sw0;
    logic [2:0] a, b, a0, b0;
    logic [3:0] q, q0;
    logic       busy, done, any_fail, busy0, done0, any_fail0;
    logic [8:0] pass_cnt, fail_cnt, pass0, fail0;
    logic [7:0] first_fail_idx, ffi0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0] flip [256];
    bit         good [256];
    bit         swept_m = 1'b0;
    int         t0 = 0;
    int         run_len = 256;
    int         prev_idx = 0;
    bit         active0 = 1'b0;
    int         t00 = 0;
    logic [7:0] last0 = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU results from the operation definitions, in plain integer arithmetic.
    function automatic logic [3:0] gold(input logic [7:0] v);
        int op, x, y, r;
        op = int'(v[7:6]);
        x  = int'(v[5:3]);
        y  = int'(v[2:0]);
        case (op)
            0:       r = x + y;
            1:       r = ((x < y) ? 8 : 0) + ((x - y + 8) % 8);
            2:       r = 7 - (x ^ y);
            default: r = x / 2;
        endcase
        return 4'(r);
    endfunction

    assign q  = gold({sw, a, b}) ^ flip[{sw, a, b}];
    assign q0 = gold({sw0, a0, b0});

    alu_vector_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start),
        .swSelect(sw), .a(a), .b(b), .q(q),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .any_fail(any_fail)
    );

    alu_vector_sequencer #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .swSelect(sw0), .a(a0), .b(b0), .q(q0),
        .busy(busy0), .done(done0), .pass_cnt(pass0), .fail_cnt(fail0),
        .first_fail_idx(ffi0), .any_fail(any_fail0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_start();
        int first;
        first = -1;
        for (int v = 0; v < 256; v++) begin
            good[v] = (flip[v] == 4'h0);
            if (!good[v] && first < 0) first = v;
        end
        run_len = (STOP && first >= 0) ? first + 1 : 256;
    endtask

    // Start is honoured only when the sweep model says the sequencer was idle or done.
    task automatic pulse_start(input bit with0);
        @(negedge clk);
        start = 1'b1;
        if (with0) start0 = 1'b1;
        @(posedge clk);
        #1;
        if (!swept_m || (cyc - 1 - t0) >= run_len * P) begin
            prev_idx = swept_m ? run_len - 1 : 0;
            model_start();
            t0 = cyc;
            swept_m = 1'b1;
        end
        if (with0) begin
            active0 = 1'b1;
            t00 = cyc;
        end
        start = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        for (int i = 0; i < 3000 && done !== 1'b1; i++) @(negedge clk);
        chk({name, "_done_seen"}, done, 1);
        if (exp_lat > 0) chk({name, "_done_latency"}, cyc - t0, exp_lat);
        $display("sweep %s: pass=%0d fail=%0d first_idx=%0h any=%0d", name,
                 pass_cnt, fail_cnt, first_fail_idx, any_fail);
    endtask

    // Per-cycle comparison against the sweep model for the main DUT.
    always @(negedge clk) begin
        int n, k, ep, ef, efi, ei;
        bit ea;
        if (!swept_m) begin
            chk("idle_vec", {sw, a, b}, 8'h00);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_pass", pass_cnt, 0);
            chk("idle_fail", fail_cnt, 0);
            chk("idle_ffi", first_fail_idx, 8'hFF);
            chk("idle_any", any_fail, 0);
        end else begin
            n = cyc - t0;
            k = n / P;
            if (k > run_len) k = run_len;
            ep = 0; ef = 0; efi = 255; ea = 1'b0;
            for (int v = 0; v < k; v++) begin
                if (good[v]) ep++;
                else begin
                    ef++;
                    if (!ea) begin efi = v; ea = 1'b1; end
                end
            end
            if (n == 0) ei = prev_idx;
            else begin
                ei = (n - 1) / P;
                if (ei > run_len - 1) ei = run_len - 1;
            end
            chk("vec", {sw, a, b}, ei);
            chk("busy", busy, n < run_len * P);
            chk("done", done, n >= run_len * P + 1);
            chk("pass_cnt", pass_cnt, ep);
            chk("fail_cnt", fail_cnt, ef);
            chk("first_fail_idx", first_fail_idx, efi);
            chk("any_fail", any_fail, ea);
        end
    end

    // Zero-settle instance: vector order, drive-edge-only changes and done latency.
    always @(negedge clk) begin
        int n0;
        if (active0) begin
            n0 = cyc - t00;
            if ({sw0, a0, b0} != last0) chk("s0_change_on_drive", n0 % P0, 1);
            last0 = {sw0, a0, b0};
            if (n0 >= 1 && n0 <= 512) chk("s0_vec", {sw0, a0, b0}, (n0 - 1) / P0);
            if (n0 == 512) chk("s0_done_early", done0, 0);
            if (n0 == 513) begin
                chk("s0_done", done0, 1);
                chk("s0_pass", pass0, 256);
                chk("s0_fail", fail0, 0);
                chk("s0_ffi", ffi0, 8'hFF);
                $display("sweep settle0: pass=%0d fail=%0d", pass0, fail0);
                active0 = 1'b0;
            end
        end
    end

    initial begin
        logic [3:0] gv;
        for (int v = 0; v < 256; v++) flip[v] = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean sweep, a start re-pulse mid-sweep, then a restart after done.
        pulse_start(1'b1);
        repeat (300) @(negedge clk);
        pulse_start(1'b0);
        wait_done("clean", 1025);
        chk("clean_pass", pass_cnt, 256);
        chk("clean_fail", fail_cnt, 0);
        chk("clean_ffi", first_fail_idx, 8'hFF);
        chk("clean_any", any_fail, 0);
        repeat (5) @(negedge clk);
        pulse_start(1'b0);
        wait_done("rerun", 1025);
        chk("rerun_pass", pass_cnt, 256);
        chk("rerun_fail", fail_cnt, 0);

        // Carry bit stuck low on the add op.
        for (int v = 0; v < 256; v++) begin
            gv = gold(8'(v));
            flip[v] = (v < 64 && gv[3]) ? 4'h8 : 4'h0;
        end
        pulse_start(1'b0);
        wait_done("carry_fault", 0);
        if (STOP) begin
            chk("stop_pass", pass_cnt, 15);
            chk("stop_fail", fail_cnt, 1);
            chk("stop_latency", cyc - t0, 16 * P + 1);
        end else begin
            chk("carry_pass", pass_cnt, 228);
            chk("carry_fail", fail_cnt, 28);
        end
        chk("carry_ffi", first_fail_idx, 8'h0F);
        chk("carry_any", any_fail, 1);

        // Randomly corrupted results.
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 256; v++)
                flip[v] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            pulse_start(1'b0);
            wait_done("random", 0);
        end

        // Asynchronous reset between edges in the middle of a clean sweep.
        for (int v = 0; v < 256; v++) flip[v] = 4'h0;
        pulse_start(1'b0);
        repeat (500) @(posedge clk);
        #3;
        rst = 1'b1;
        swept_m = 1'b0;
        #1;
        chk("arst_vec", {sw, a, b}, 8'h00);
        chk("arst_busy", busy, 0);
        chk("arst_pass", pass_cnt, 0);
        chk("arst_fail", fail_cnt, 0);
        chk("arst_ffi", first_fail_idx, 8'hFF);
        chk("arst_any", any_fail, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
